// File: rtl/exe_wb_arbiter_pkg.sv
// exe_wb_arbiter_pkg: shared payload widths, FU slot indices and the writeback payload type.
package exe_wb_arbiter_pkg;
    localparam int ROB_WB_WIDTH = 16;
    localparam int REG_WB_WIDTH = 12;
    localparam int CDB_WIDTH    = 8;
    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_MUL  = 2;
    localparam int FU_DIV  = 3;
    localparam int FU_LSU  = 4;
    localparam int FU_BRU  = 5;
    typedef struct packed {
        logic [ROB_WB_WIDTH-1:0] rob;
        logic [REG_WB_WIDTH-1:0] rf;
    } wb_payload_t;
endpackage

// File: rtl/exe_wb_arbiter_wb_result_fifo.sv
// wb_result_fifo: per-FU result FIFO with push/pop/flush; exposes head entry and occupancy.
//   clk_i/reset_i  clock, synchronous active-high reset
//   flush_i        empties the FIFO, same-cycle push/pop discarded
//   push_i/data_i  enqueue (caller guarantees not full)
//   pop_i          dequeue (caller guarantees not empty)
//   head_o/count_o oldest entry and current occupancy
module wb_result_fifo #(
    parameter int DEPTH_P = 2,
    parameter int WIDTH_P = 28
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH_P-1:0]         data_i,
    input  logic                       pop_i,
    output logic [WIDTH_P-1:0]         head_o,
    output logic [$clog2(DEPTH_P):0]   count_o
);
    localparam int AW = $clog2(DEPTH_P);
    localparam int CW = AW + 1;
    logic [WIDTH_P-1:0] mem [DEPTH_P];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i) rd_ptr <= rd_ptr + AW'(1);
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end
    // Storage is not reset: a flushed or reset FIFO's pointers make stale data unreachable.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end
    assign head_o = mem[rd_ptr];
endmodule

// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter: buffers FU results in per-FU FIFOs and grants up to NUM_CDB_P writebacks per cycle round-robin.
//   clk_i/reset_i          clock, synchronous active-high reset (priority over mispredict_i)
//   fu_v_i/fu_ready_o      per-FU result handshake
//   fu_rob_i/fu_reg_i      per-FU ROB and register payloads
//   wb_v_o/wb_rob_o/wb_reg_o registered per-channel writeback
//   cdb_o                  upper CDB_WIDTH_P bits of each channel's ROB payload
//   mispredict_i           flushes all FIFOs and output channels
//   stall_cnt_o            per-FU stall counters, only with WB_PERF_CNT_EN defined
module exe_wb_arbiter
    import exe_wb_arbiter_pkg::*;
#(
    parameter int NUM_FU_P       = 6,
    parameter int NUM_CDB_P      = 2,
    parameter int FIFO_DEPTH_P   = 2,
    parameter int ROB_WB_WIDTH_P = ROB_WB_WIDTH,
    parameter int REG_WB_WIDTH_P = REG_WB_WIDTH,
    parameter int CDB_WIDTH_P    = CDB_WIDTH
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [NUM_FU_P-1:0]                       fu_v_i,
    output logic [NUM_FU_P-1:0]                       fu_ready_o,
    input  logic [NUM_FU_P-1:0][ROB_WB_WIDTH_P-1:0]   fu_rob_i,
    input  logic [NUM_FU_P-1:0][REG_WB_WIDTH_P-1:0]   fu_reg_i,
    output logic [NUM_CDB_P-1:0]                      wb_v_o,
    output logic [NUM_CDB_P-1:0][ROB_WB_WIDTH_P-1:0]  wb_rob_o,
    output logic [NUM_CDB_P-1:0][REG_WB_WIDTH_P-1:0]  wb_reg_o,
    output logic [NUM_CDB_P-1:0][CDB_WIDTH_P-1:0]     cdb_o,
    input  logic                                      mispredict_i
`ifdef WB_PERF_CNT_EN
    ,
    output logic [NUM_FU_P-1:0][31:0]                 stall_cnt_o
`endif
);
    localparam int FW = (NUM_FU_P > 1) ? $clog2(NUM_FU_P) : 1;
    localparam int CW = $clog2(FIFO_DEPTH_P) + 1;
    localparam int PW = ROB_WB_WIDTH_P + REG_WB_WIDTH_P;

    logic [NUM_FU_P-1:0][CW-1:0] count;
    logic [NUM_FU_P-1:0][PW-1:0] head;
    logic [NUM_FU_P-1:0] nonempty, grant, push;
    logic [FW-1:0] rr_ptr, rr_nxt;
    logic [NUM_CDB_P-1:0] nxt_v;
    logic [NUM_CDB_P-1:0][ROB_WB_WIDTH_P-1:0] nxt_rob;
    logic [NUM_CDB_P-1:0][REG_WB_WIDTH_P-1:0] nxt_reg;
    int pos [NUM_FU_P];
    int rank [NUM_FU_P];
    int last_pos;

    for (genvar f = 0; f < NUM_FU_P; f++) begin : g_fifo
        // Ready comes from the registered count only, so a full FIFO stays not-ready even while popping.
        assign fu_ready_o[f] = count[f] != CW'(FIFO_DEPTH_P);
        assign nonempty[f]   = count[f] != '0;
        assign push[f]       = fu_v_i[f] & fu_ready_o[f];
        wb_result_fifo #(
            .DEPTH_P (FIFO_DEPTH_P),
            .WIDTH_P (PW)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (mispredict_i),
            .push_i  (push[f]),
            .data_i  ({fu_rob_i[f], fu_reg_i[f]}),
            .pop_i   (grant[f]),
            .head_o  (head[f]),
            .count_o (count[f])
        );
    end

    // pos is each FU's distance from rr_ptr in scan order; rank counts non-empty FUs scanned before it,
    // which is both the grant test and the channel it lands on.
    always_comb begin
        grant    = '0;
        nxt_v    = '0;
        nxt_rob  = '0;
        nxt_reg  = '0;
        last_pos = -1;
        for (int f = 0; f < NUM_FU_P; f++) begin
            pos[f] = (f - int'(rr_ptr) + NUM_FU_P) % NUM_FU_P;
        end
        for (int f = 0; f < NUM_FU_P; f++) begin
            rank[f] = 0;
            for (int g = 0; g < NUM_FU_P; g++) begin
                if (nonempty[g] && pos[g] < pos[f]) rank[f]++;
            end
            grant[f] = nonempty[f] && rank[f] < NUM_CDB_P;
            if (grant[f] && pos[f] > last_pos) last_pos = pos[f];
        end
        for (int c = 0; c < NUM_CDB_P; c++) begin
            for (int f = 0; f < NUM_FU_P; f++) begin
                if (grant[f] && rank[f] == c) begin
                    nxt_v[c]   = 1'b1;
                    nxt_rob[c] = head[f][PW-1 -: ROB_WB_WIDTH_P];
                    nxt_reg[c] = head[f][REG_WB_WIDTH_P-1:0];
                end
            end
        end
        rr_nxt = (last_pos < 0) ? rr_ptr : FW'((int'(rr_ptr) + last_pos + 1) % NUM_FU_P);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) rr_ptr <= '0;
        else if (!mispredict_i) rr_ptr <= rr_nxt;
        if (reset_i || mispredict_i) begin
            wb_v_o   <= '0;
            wb_rob_o <= '0;
            wb_reg_o <= '0;
        end else begin
            wb_v_o   <= nxt_v;
            wb_rob_o <= nxt_rob;
            wb_reg_o <= nxt_reg;
        end
    end

    for (genvar c = 0; c < NUM_CDB_P; c++) begin : g_cdb
        assign cdb_o[c] = wb_rob_o[c][ROB_WB_WIDTH_P-1 -: CDB_WIDTH_P];
    end

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk_i) begin
        for (int f = 0; f < NUM_FU_P; f++) begin
            if (reset_i) stall_cnt_o[f] <= '0;
            else if (nonempty[f] && !grant[f] && stall_cnt_o[f] != '1) stall_cnt_o[f] <= stall_cnt_o[f] + 32'd1;
        end
    end
`endif

    a_push_when_ready: assert property (@(posedge clk_i) disable iff (reset_i) (fu_v_i & ~fu_ready_o) == '0);
endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb_exe_wb_arbiter: directed vector table, hand sequences and randomized traffic against a queue-based model.
module tb_exe_wb_arbiter;
    import exe_wb_arbiter_pkg::*;
    localparam int NF = 6;
    localparam int NC = 2;
    localparam int DEPTH = 2;
    localparam int RW = ROB_WB_WIDTH;
    localparam int GW = REG_WB_WIDTH;
    localparam int BW = CDB_WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic misp = 1'b0;
    logic [NF-1:0] fu_v = '0;
    logic [NF-1:0] fu_ready;
    logic [NF-1:0][RW-1:0] fu_rob = '0;
    logic [NF-1:0][GW-1:0] fu_reg = '0;
    logic [NC-1:0] wb_v;
    logic [NC-1:0][RW-1:0] wb_rob;
    logic [NC-1:0][GW-1:0] wb_reg;
    logic [NC-1:0][BW-1:0] cdb;
`ifdef WB_PERF_CNT_EN
    logic [NF-1:0][31:0] stall_cnt;
    longint m_stall [NF];
`endif

    always #5 clk = ~clk;

    exe_wb_arbiter #(
        .NUM_FU_P(NF), .NUM_CDB_P(NC), .FIFO_DEPTH_P(DEPTH)
    ) dut (
        .clk_i(clk), .reset_i(reset), .fu_v_i(fu_v), .fu_ready_o(fu_ready),
        .fu_rob_i(fu_rob), .fu_reg_i(fu_reg), .wb_v_o(wb_v), .wb_rob_o(wb_rob),
        .wb_reg_o(wb_reg), .cdb_o(cdb), .mispredict_i(misp)
`ifdef WB_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a payload queue per FU, a scan-start index and the expected output registers.
    wb_payload_t q [NF][$];
    logic [NC-1:0] m_v = '0;
    wb_payload_t m_out [NC];
    int m_rr = 0;

    typedef struct {
        bit rst;
        bit misp;
        logic [NF-1:0] v;
        logic [NC-1:0] ev;
        int f0, r0, f1, r1;
        logic [NF-1:0] er;
    } vec_t;
    vec_t tbl [19];

    function automatic wb_payload_t mk(input int row, input int f);
        wb_payload_t p;
        p.rob = RW'(row * 256 + f * 16 + 5);
        p.rf  = GW'(row * 16 + f);
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NF-1:0] model_ready();
        logic [NF-1:0] r;
        for (int f = 0; f < NF; f++) r[f] = q[f].size() < DEPTH;
        return r;
    endfunction

    task automatic model_edge();
        logic [NF-1:0] rdy;
        logic [NC-1:0] nv;
        wb_payload_t no [NC];
        int n, last;
        if (reset) begin
            for (int f = 0; f < NF; f++) q[f].delete();
            m_v = '0;
            for (int c = 0; c < NC; c++) m_out[c] = '0;
            m_rr = 0;
`ifdef WB_PERF_CNT_EN
            for (int f = 0; f < NF; f++) m_stall[f] = 0;
`endif
            return;
        end
        rdy = model_ready();
        nv = '0;
        for (int c = 0; c < NC; c++) no[c] = '0;
        n = 0;
        last = -1;
        for (int i = 0; i < NF; i++) begin
            int f;
            f = (m_rr + i) % NF;
            if (q[f].size() > 0 && n < NC) begin
                no[n] = q[f].pop_front();
                nv[n] = 1'b1;
                n++;
                last = f;
            end else if (q[f].size() > 0) begin
`ifdef WB_PERF_CNT_EN
                if (m_stall[f] < 64'hFFFF_FFFF) m_stall[f]++;
`endif
            end
        end
        if (misp) begin
            for (int f = 0; f < NF; f++) q[f].delete();
            m_v = '0;
            for (int c = 0; c < NC; c++) m_out[c] = '0;
        end else begin
            m_v = nv;
            for (int c = 0; c < NC; c++) m_out[c] = no[c];
            if (last >= 0) m_rr = (last + 1) % NF;
            for (int f = 0; f < NF; f++) begin
                if (fu_v[f] && rdy[f]) begin
                    wb_payload_t p;
                    p.rob = fu_rob[f];
                    p.rf  = fu_reg[f];
                    q[f].push_back(p);
                end
            end
        end
    endtask

    task automatic check_model();
        chk("model wb_v", 64'(wb_v), 64'(m_v));
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("model wb_rob[%0d]", c), 64'(wb_rob[c]), 64'(m_out[c].rob));
            chk($sformatf("model wb_reg[%0d]", c), 64'(wb_reg[c]), 64'(m_out[c].rf));
            chk($sformatf("model cdb[%0d]", c), 64'(cdb[c]), 64'(m_out[c].rob[RW-1 -: BW]));
        end
        chk("model fu_ready", 64'(fu_ready), 64'(model_ready()));
`ifdef WB_PERF_CNT_EN
        for (int f = 0; f < NF; f++) chk($sformatf("model stall[%0d]", f), 64'(stall_cnt[f]), 64'(m_stall[f]));
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 6'h00, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[1]  = '{0, 0, 6'h04, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[2]  = '{0, 0, 6'h00, 2'b01, 2, 1, 0, 0, 6'h3F};
        tbl[3]  = '{1, 0, 6'h00, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[4]  = '{0, 0, 6'h2B, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[5]  = '{0, 0, 6'h00, 2'b11, 0, 4, 1, 4, 6'h3F};
        tbl[6]  = '{0, 0, 6'h00, 2'b11, 3, 4, 5, 4, 6'h3F};
        tbl[7]  = '{0, 0, 6'h01, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[8]  = '{0, 0, 6'h00, 2'b01, 0, 7, 0, 0, 6'h3F};
        tbl[9]  = '{0, 0, 6'h07, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[10] = '{0, 0, 6'h01, 2'b11, 1, 9, 2, 9, 6'h3E};
        tbl[11] = '{0, 0, 6'h00, 2'b01, 0, 9, 0, 0, 6'h3F};
        tbl[12] = '{0, 0, 6'h00, 2'b01, 0, 10, 0, 0, 6'h3F};
        tbl[13] = '{0, 0, 6'h38, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[14] = '{0, 1, 6'h02, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[15] = '{0, 0, 6'h00, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[16] = '{0, 0, 6'h03, 2'b00, 0, 0, 0, 0, 6'h3F};
        tbl[17] = '{0, 0, 6'h00, 2'b11, 1, 16, 0, 16, 6'h3F};
        tbl[18] = '{0, 0, 6'h00, 2'b00, 0, 0, 0, 0, 6'h3F};

        for (int r = 0; r < 19; r++) begin
            wb_payload_t e0, e1;
            reset = tbl[r].rst;
            misp  = tbl[r].misp;
            fu_v  = tbl[r].v;
            for (int f = 0; f < NF; f++) begin
                wb_payload_t p;
                p = mk(r, f);
                fu_rob[f] = p.rob;
                fu_reg[f] = p.rf;
            end
            cycle();
            e0 = tbl[r].ev[0] ? mk(tbl[r].r0, tbl[r].f0) : '0;
            e1 = tbl[r].ev[1] ? mk(tbl[r].r1, tbl[r].f1) : '0;
            chk($sformatf("row%0d wb_v", r), 64'(wb_v), 64'(tbl[r].ev));
            chk($sformatf("row%0d rob0", r), 64'(wb_rob[0]), 64'(e0.rob));
            chk($sformatf("row%0d rob1", r), 64'(wb_rob[1]), 64'(e1.rob));
            chk($sformatf("row%0d reg0", r), 64'(wb_reg[0]), 64'(e0.rf));
            chk($sformatf("row%0d reg1", r), 64'(wb_reg[1]), 64'(e1.rf));
            chk($sformatf("row%0d cdb0", r), 64'(cdb[0]), 64'(r == 2 ? 1 : e0.rob[RW-1 -: BW]));
            chk($sformatf("row%0d ready", r), 64'(fu_ready), 64'(tbl[r].er));
        end
        reset = 1'b0;
        misp = 1'b0;
        fu_v = '0;

        // Single result: two edges from fu_v to wb_v, CDB carries the upper ROB bits.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        fu_v = 6'h04;
        fu_rob[2] = 16'h1234;
        fu_reg[2] = 12'h0AB;
        cycle();
        chk("single wb_v after 1 edge", 64'(wb_v), 64'h0);
        fu_v = '0;
        cycle();
        chk("single wb_v", 64'(wb_v), 64'h1);
        chk("single rob0", 64'(wb_rob[0]), 64'h1234);
        chk("single reg0", 64'(wb_reg[0]), 64'h0AB);
        chk("single cdb0", 64'(cdb[0]), 64'h12);
        cycle();
        chk("single drained", 64'(wb_v), 64'h0);

        // Randomized traffic, heavy enough to keep FIFOs contending, with sparse flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [NF-1:0] rdy;
            int load;
            rdy = model_ready();
            load = (i / 500) % 3;
            reset = $urandom_range(0, 499) == 0;
            misp  = $urandom_range(0, 39) == 0;
            for (int f = 0; f < NF; f++) begin
                fu_v[f]   = rdy[f] && ($urandom_range(0, 3) < load + 1);
                fu_rob[f] = RW'($urandom);
                fu_reg[f] = GW'($urandom);
            end
            cycle();
        end
        reset = 1'b0;
        misp = 1'b0;
        fu_v = '0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
